// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared definitions for the FPU issue controller: rounding modes,
// fflags bit positions and rounding-mode helpers.
package fpu_issue_ctrl_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100,
        RM_DYN = 3'b111
    } rm_e;

    localparam int unsigned FF_NX    = 0;
    localparam int unsigned FF_UF    = 1;
    localparam int unsigned FF_OF    = 2;
    localparam int unsigned FF_DZ    = 3;
    localparam int unsigned FF_NV    = 4;
    localparam int unsigned FFLAGS_W = 5;
    localparam int unsigned RESULT_W = 32;

    // 101 and 110 are reserved; 111 is only meaningful before resolution
    function automatic logic rm_legal(input logic [2:0] r);
        return (r <= RM_RMM);
    endfunction

    function automatic logic [2:0] rm_resolve(input logic [2:0] r, input logic [2:0] frm);
        return (r == RM_DYN) ? frm : r;
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_order_fifo.sv
// Order FIFO holding the unit index of each in-flight request;
// registered pointers with occupancy count, full and empty flags.
module fpu_issue_ctrl_order_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer: routes requests to FPU units, resolves rounding mode,
// and retires unit results strictly in issue order.
module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned UNIT_W    = $clog2(NUM_UNITS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic [UNIT_W-1:0]        sel,
    input  logic [2:0]               rm,
    input  logic [2:0]               frm,
    output logic [NUM_UNITS-1:0]     unit_valid_out,
    input  logic [NUM_UNITS-1:0]     unit_ready_in,
    output logic [2:0]               unit_rm_out,
    input  logic [NUM_UNITS-1:0]     unit_valid_in,
    output logic [NUM_UNITS-1:0]     unit_ready_out,
    input  logic [32*NUM_UNITS-1:0]  unit_result_in,
    input  logic [5*NUM_UNITS-1:0]   unit_flags_in,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [31:0]              result_out,
    output logic [4:0]               flags_out,
    output logic                     illegal_out,
    output logic [$clog2(DEPTH):0]   in_flight
);

    logic [2:0]        rm_res;
    logic              rm_ok;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              sel_rdy;
    logic              head_valid;
    logic [UNIT_W-1:0] head;

    assign rm_res      = rm_resolve(rm, frm);
    assign rm_ok       = rm_legal(rm_res);
    assign unit_rm_out = rm_res;

    // Loop-based select keeps out-of-range sel harmless when NUM_UNITS is not a power of two
    always_comb begin
        sel_rdy        = 1'b0;
        unit_valid_out = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (sel == UNIT_W'(i)) begin
                sel_rdy           = unit_ready_in[i];
                unit_valid_out[i] = valid_in && rm_ok && !full;
            end
        end
    end

    // Illegal rounding modes are consumed without touching any unit
    assign ready_out = valid_in && (!rm_ok || (!full && sel_rdy));
    assign push      = valid_in && rm_ok && !full && sel_rdy;

    always_comb begin
        head_valid     = 1'b0;
        result_out     = '0;
        flags_out      = '0;
        unit_ready_out = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            unit_ready_out[i] = ready_in && (empty || head == UNIT_W'(i));
            if (!empty && head == UNIT_W'(i)) begin
                head_valid = unit_valid_in[i];
                result_out = unit_result_in[32*i +: 32];
                flags_out  = unit_flags_in[5*i +: 5];
            end
        end
    end

    assign valid_out = head_valid;
    assign pop       = head_valid && ready_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_out <= 1'b0;
        end else begin
            illegal_out <= valid_in && !rm_ok;
        end
    end

    fpu_issue_ctrl_order_fifo #(
        .DEPTH (DEPTH),
        .W     (UNIT_W)
    ) u_order_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (sel),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (in_flight)
    );

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl with behavioural latency-modelled units.
module tb_fpu_issue_ctrl;

    localparam int NU = 4;
    localparam int DP = 4;
    localparam int UW = 2;

    logic              clk;
    logic              reset;
    logic              valid_in;
    logic              ready_out;
    logic [UW-1:0]     sel;
    logic [2:0]        rm;
    logic [2:0]        frm;
    logic [NU-1:0]     unit_valid_out;
    logic [NU-1:0]     unit_ready_in;
    logic [2:0]        unit_rm_out;
    logic [NU-1:0]     unit_valid_in;
    logic [NU-1:0]     unit_ready_out;
    logic [32*NU-1:0]  unit_result_in;
    logic [5*NU-1:0]   unit_flags_in;
    logic              valid_out;
    logic              ready_in;
    logic [31:0]       result_out;
    logic [4:0]        flags_out;
    logic              illegal_out;
    logic [2:0]        in_flight;
    logic [31:0]       op_data;

    typedef struct {
        logic [31:0] d;
        int          due;
    } ent_t;

    typedef struct {
        logic [31:0] r;
        logic [4:0]  f;
    } exp_t;

    ent_t uq [NU][$];
    exp_t exp_q [$];
    exp_t mon_e;
    int   lat [NU] = '{1, 2, 8, 3};
    int   cyc;
    int   checks;
    int   errors;

    logic [NU-1:0] acc_s;
    logic [NU-1:0] ret_s;
    logic [31:0]   data_s;

    fpu_issue_ctrl #(
        .NUM_UNITS (NU),
        .DEPTH     (DP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .sel            (sel),
        .rm             (rm),
        .frm            (frm),
        .unit_valid_out (unit_valid_out),
        .unit_ready_in  (unit_ready_in),
        .unit_rm_out    (unit_rm_out),
        .unit_valid_in  (unit_valid_in),
        .unit_ready_out (unit_ready_out),
        .unit_result_in (unit_result_in),
        .unit_flags_in  (unit_flags_in),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .result_out     (result_out),
        .flags_out      (flags_out),
        .illegal_out    (illegal_out),
        .in_flight      (in_flight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unit model: handshakes sampled mid-cycle, applied on the next rising edge
    always @(negedge clk) begin
        acc_s  = unit_valid_out & unit_ready_in;
        ret_s  = unit_valid_in & unit_ready_out;
        data_s = op_data;
    end

    always @(posedge clk or posedge reset) begin
        logic [NU-1:0]    v;
        logic [32*NU-1:0] r;
        logic [5*NU-1:0]  f;
        if (reset) begin
            for (int i = 0; i < NU; i++) uq[i].delete();
            cyc   = 0;
            acc_s = '0;
            ret_s = '0;
        end else begin
            cyc++;
            for (int i = 0; i < NU; i++) begin
                if (ret_s[i] && uq[i].size() > 0) void'(uq[i].pop_front());
                if (acc_s[i]) uq[i].push_back('{data_s, cyc + lat[i] - 1});
            end
        end
        v = '0;
        r = '0;
        f = '0;
        for (int i = 0; i < NU; i++) begin
            if (uq[i].size() > 0 && uq[i][0].due <= cyc) begin
                v[i]          = 1'b1;
                r[32*i +: 32] = uq[i][0].d;
                f[5*i +: 5]   = uq[i][0].d[7:3];
            end
        end
        unit_valid_in  <= v;
        unit_result_in <= r;
        unit_flags_in  <= f;
    end

    // Monitor: every retirement is compared against the oldest expectation
    always @(negedge clk) begin
        if (!reset && valid_out && ready_in) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL retire_unexpected: got result %h flags %b, expected nothing", result_out, flags_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (result_out !== mon_e.r || flags_out !== mon_e.f) begin
                    errors++;
                    $display("FAIL retire: got result %h flags %b, expected result %h flags %b",
                             result_out, flags_out, mon_e.r, mon_e.f);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input int u, input logic [2:0] r, input logic [31:0] d);
        logic [2:0] res;
        logic       ok;
        bit         got;
        res = (r == 3'b111) ? frm : r;
        ok  = (res < 3'd5);
        @(posedge clk); #1;
        valid_in = 1'b1;
        sel      = UW'(u);
        rm       = r;
        op_data  = d;
        got      = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (ready_out) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            chk("issue_timeout", 32'd0, 32'd1);
        end else begin
            chk("issue_onehot", 32'(unit_valid_out), ok ? (32'd1 << u) : 32'd0);
            chk("issue_rm", 32'(unit_rm_out), 32'(res));
            if (ok) exp_q.push_back('{d, d[7:3]});
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_q.size() > 0; n++) @(negedge clk);
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        valid_in      = 1'b0;
        ready_in      = 1'b1;
        unit_ready_in = '1;
        sel           = '0;
        rm            = 3'b000;
        frm           = 3'b000;
        op_data       = '0;
        #3;
        chk("rst_in_flight", 32'(in_flight), 32'd0);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_ready_out", 32'(ready_out), 32'd0);
        chk("rst_unit_valid", 32'(unit_valid_out), 32'd0);
        chk("rst_illegal", 32'(illegal_out), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single issue, 1-cycle unit
        issue(0, 3'b000, 32'h3F800000);
        @(negedge clk);
        chk("single_valid_next", 32'(valid_out), 32'd1);
        chk("single_result_next", result_out, 32'h3F800000);
        drain();
        chk("single_in_flight", 32'(in_flight), 32'd0);

        // Slow unit 2 then fast unit 0: unit 0 must wait behind unit 2
        issue(2, 3'b001, 32'h4000_00A8);
        issue(0, 3'b000, 32'h4040_0050);
        @(negedge clk);
        chk("reorder_hold_ready", 32'(unit_ready_out[0]), 32'd0);
        chk("reorder_hold_valid", 32'(valid_out), 32'd0);
        drain();
        chk("reorder_in_flight", 32'(in_flight), 32'd0);

        // Dynamic rounding mode
        frm = 3'b010;
        issue(1, 3'b111, 32'h4080_00F0);
        drain();
        frm = 3'b101;
        issue(1, 3'b111, 32'h4100_0018);
        @(negedge clk);
        chk("dyn_illegal_pulse", 32'(illegal_out), 32'd1);
        chk("dyn_illegal_inflight", 32'(in_flight), 32'd0);
        @(negedge clk);
        chk("dyn_illegal_clear", 32'(illegal_out), 32'd0);
        frm = 3'b000;

        // Fill the FIFO with writeback stalled
        ready_in = 1'b0;
        for (int k = 0; k < DP; k++) issue(1, 3'b000, 32'h5000_0000 + 32'(k * 8));
        @(negedge clk);
        chk("full_in_flight", 32'(in_flight), 32'd4);
        issue(3, 3'b101, 32'h5100_0000);
        @(negedge clk);
        chk("full_illegal_pulse", 32'(illegal_out), 32'd1);
        chk("full_illegal_inflight", 32'(in_flight), 32'd4);
        @(posedge clk); #1;
        valid_in = 1'b1;
        sel      = 2'd3;
        rm       = 3'b000;
        op_data  = 32'h5200_0038;
        ready_in = 1'b1;
        @(negedge clk);
        chk("full_no_accept", 32'(ready_out), 32'd0);
        chk("full_no_unit_valid", 32'(unit_valid_out), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_accept_next", 32'(ready_out), 32'd1);
        chk("full_unit_valid_next", 32'(unit_valid_out), 32'b1000);
        if (ready_out) exp_q.push_back('{32'h5200_0038, 5'b00111});
        @(posedge clk); #1;
        valid_in = 1'b0;
        drain();
        chk("full_in_flight_end", 32'(in_flight), 32'd0);

        // Back-pressure on a valid head
        ready_in = 1'b0;
        issue(0, 3'b011, 32'h3FC0_0090);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(valid_out), 32'd1);
            chk("bp_result", result_out, 32'h3FC0_0090);
            chk("bp_in_flight", 32'(in_flight), 32'd1);
        end
        @(posedge clk); #1;
        ready_in = 1'b1;
        drain();
        chk("bp_in_flight_end", 32'(in_flight), 32'd0);

        // Asynchronous reset with three requests outstanding
        ready_in = 1'b0;
        issue(1, 3'b000, 32'h6000_0008);
        issue(2, 3'b000, 32'h6000_0010);
        issue(3, 3'b000, 32'h6000_0018);
        @(negedge clk);
        chk("rstmid_in_flight_before", 32'(in_flight), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_in_flight", 32'(in_flight), 32'd0);
        chk("rstmid_valid_out", 32'(valid_out), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset    = 1'b0;
        ready_in = 1'b1;
        @(negedge clk);
        chk("rstmid_in_flight_after", 32'(in_flight), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
